// File: rtl/pix_pair_pkg.sv
// Shared constants for the pixel-pair un-swap path: default widths, sync idle levels, pair-phase codes.
package pix_pair_pkg;

    localparam int   DATA_WIDTH_DEF  = 8;
    localparam int   CNT_WIDTH_DEF   = 16;
    localparam logic SWAP_PARITY_DEF = 1'b1;

    // Levels the sync outputs sit at while the block is held in reset
    localparam logic VS_IDLE = 1'b1;
    localparam logic HS_IDLE = 1'b1;
    localparam logic DE_IDLE = 1'b0;

    localparam logic PH_FIRST  = 1'b0;
    localparam logic PH_SECOND = 1'b1;

endpackage

// File: rtl/pix_sync_dly.sv
// N-stage delay line for sync/enable bits, each bit with its own reset level.
// Latency: N pix_clk cycles. No backpressure: free-running pixel stream.
module pix_sync_dly #(
    parameter int             N       = 2,
    parameter int             W       = 3,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         pix_clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stg [N];

    always_ff @(posedge pix_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) stg[i] <= RST_VAL;
        end else begin
            stg[0] <= din;
            for (int i = 1; i < N; i++) stg[i] <= stg[i-1];
        end
    end

    assign dout = stg[N-1];

endmodule

// File: rtl/pix_pair_unswap.sv
// Restores raster order on alternate lines whose adjacent pixel pairs were swapped upstream.
// Latency: 2 pix_clk cycles for sync and data on every line. No backpressure.
// PIX_PAIR_ODD_CNT_EN adds a per-frame count of odd-length lines on odd_line_cnt.
module pix_pair_unswap
    import pix_pair_pkg::*;
#(
    parameter int   C_DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter logic C_SWAP_PARITY = SWAP_PARITY_DEF,
    parameter int   C_CNT_WIDTH   = CNT_WIDTH_DEF
) (
    input  logic                    pix_clk,
    input  logic                    reset,
    input  logic                    vs_in,
    input  logic                    hs_in,
    input  logic                    de_in,
    input  logic [C_DATA_WIDTH-1:0] data_in,
    output logic                    vs_out,
    output logic                    hs_out,
    output logic                    de_out,
    output logic [C_DATA_WIDTH-1:0] data_out,
    output logic [C_CNT_WIDTH-1:0]  odd_line_cnt
);

    logic [2:0] sync_dly;

    pix_sync_dly #(
        .N       (2),
        .W       (3),
        .RST_VAL ({VS_IDLE, HS_IDLE, DE_IDLE})
    ) u_sync_dly (
        .pix_clk (pix_clk),
        .reset   (reset),
        .din     ({vs_in, hs_in, de_in}),
        .dout    (sync_dly)
    );

    assign {vs_out, hs_out, de_out} = sync_dly;

    logic                    line_parity;
    logic                    pair_phase;
    logic                    line_swap;
    logic                    de_d1;
    logic                    ph_d1;
    logic                    swap_d1;
    logic [C_DATA_WIDTH-1:0] data_d1;
    logic [C_DATA_WIDTH-1:0] data_d2;
    logic [C_DATA_WIDTH-1:0] data_sel;
    logic                    first_pix;
    logic                    swap_cur;
    logic                    de_fall;

    assign first_pix = de_in & ~de_d1;
    assign de_fall   = de_d1 & ~de_in;
    // Swap decision is latched at the first pixel so a mid-line vs_in cannot split a line
    assign swap_cur  = first_pix ? (line_parity == C_SWAP_PARITY) : line_swap;

    // Pixel in stage 1 leaves next cycle: a first-of-pair takes its partner straight from
    // the input, a second-of-pair takes its partner from stage 2, an unpaired tail goes as is.
    always_comb begin
        data_sel = '0;
        if (de_d1) begin
            data_sel = data_d1;
            if (swap_d1) begin
                if (ph_d1 == PH_SECOND)
                    data_sel = data_d2;
                else if (de_in)
                    data_sel = data_in;
            end
        end
    end

    always_ff @(posedge pix_clk or posedge reset) begin
        if (reset) begin
            line_parity <= 1'b0;
            pair_phase  <= PH_FIRST;
            line_swap   <= 1'b0;
            de_d1       <= 1'b0;
            ph_d1       <= PH_FIRST;
            swap_d1     <= 1'b0;
            data_d1     <= '0;
            data_d2     <= '0;
            data_out    <= '0;
        end else begin
            if (vs_in)
                line_parity <= 1'b0;
            else if (de_fall)
                line_parity <= ~line_parity;
            pair_phase <= de_in ? ~pair_phase : PH_FIRST;
            line_swap  <= swap_cur;
            de_d1      <= de_in;
            ph_d1      <= pair_phase;
            swap_d1    <= swap_cur;
            data_d1    <= data_in;
            data_d2    <= data_d1;
            data_out   <= data_sel;
        end
    end

`ifdef PIX_PAIR_ODD_CNT_EN
    logic                   vs_d1;
    logic                   odd_end;
    logic [C_CNT_WIDTH-1:0] odd_cnt;
    logic [C_CNT_WIDTH-1:0] odd_cnt_inc;

    // At the falling edge the phase has already advanced past the last pixel
    assign odd_end     = de_fall & (pair_phase == PH_SECOND);
    assign odd_cnt_inc = (odd_end && !(&odd_cnt)) ? odd_cnt + C_CNT_WIDTH'(1) : odd_cnt;

    always_ff @(posedge pix_clk or posedge reset) begin
        if (reset) begin
            vs_d1        <= VS_IDLE;
            odd_cnt      <= '0;
            odd_line_cnt <= '0;
        end else begin
            vs_d1 <= vs_in;
            if (vs_in && !vs_d1) begin
                odd_line_cnt <= odd_cnt_inc;
                odd_cnt      <= '0;
            end else begin
                odd_cnt <= odd_cnt_inc;
            end
        end
    end
`else
    assign odd_line_cnt = '0;
`endif

endmodule
